// File: rtl/servo_if.sv
// Encoder/select inputs and servo outputs of servo_array, grouped as one bus.
interface servo_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8
);
    localparam int unsigned SW = $clog2(CHANNELS);

    logic                a;
    logic                b;
    logic                sel;
    logic                coarse;
    logic [SW-1:0]       chan;
    logic [WIDTH-1:0]    pos;
    logic [7:0]          level;
    logic [CHANNELS-1:0] servo;

    modport master (
        output a, b, sel, coarse,
        input  chan, pos, level, servo
    );

    modport slave (
        input  a, b, sel, coarse,
        output chan, pos, level, servo
    );
endinterface

// File: rtl/servo_array.sv
// Multi-channel encoder-driven servo controller: one saturating position per channel, glitch-free PWM.
// Define SERVO_STAGGER_EN to spread channel pulse starts evenly across the PWM period.
module servo_array #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COARSE_STEP = 8,
    parameter int unsigned PERIOD_CYC  = 1000000,
    parameter int unsigned MIN_CYC     = 50000,
    parameter int unsigned STEP_CYC    = 196
) (
    input  logic    clk,
    input  logic    rst_n,
    servo_if.slave  bus
);
    localparam int unsigned SW = $clog2(CHANNELS);
    localparam int unsigned CW = $clog2(PERIOD_CYC);
    localparam int unsigned DW = WIDTH + 1;

    localparam logic [WIDTH-1:0] POS_MID = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DW-1:0]    POS_MAX = {1'b0, {WIDTH{1'b1}}};

    // Thermometer bar from the top three position bits.
    function automatic logic [7:0] bar_of(input logic [WIDTH-1:0] p);
        logic [2:0] top;
        logic [7:0] res;
        top = p[WIDTH-1 -: 3];
        for (int i = 0; i < 8; i++) begin
            res[i] = (top >= 3'(i));
        end
        return res;
    endfunction

    logic                a_q, b_q, a_qq;
    logic [SW-1:0]       chan_q;
    logic [WIDTH-1:0]    pos_q;
    logic [7:0]          level_q;
    logic [WIDTH-1:0]    pos_arr [CHANNELS];
    logic [CW-1:0]       cnt;
    logic [CHANNELS-1:0] servo_q;

    logic                step_c;
    logic [WIDTH-1:0]    cur_c;
    logic [DW-1:0]       delta_c;
    logic [DW-1:0]       up_c;
    logic [WIDTH-1:0]    down_c;
    logic [WIDTH-1:0]    new_val_c;
    logic [WIDTH-1:0]    pos_nxt_c [CHANNELS];
    logic [SW-1:0]       chan_nxt_c;

    assign step_c = a_q & ~a_qq;

    // Saturating step on the current channel; a coincident sel moves chan afterwards.
    always_comb begin
        cur_c     = pos_arr[chan_q];
        delta_c   = bus.coarse ? DW'(COARSE_STEP) : DW'(1);
        up_c      = {1'b0, cur_c} + delta_c;
        down_c    = cur_c - delta_c[WIDTH-1:0];
        new_val_c = cur_c;
        if (b_q) begin
            new_val_c = ({1'b0, cur_c} < delta_c) ? '0 : down_c;
        end else begin
            new_val_c = (up_c > POS_MAX) ? '1 : up_c[WIDTH-1:0];
        end

        pos_nxt_c = pos_arr;
        if (step_c) begin
            pos_nxt_c[chan_q] = new_val_c;
        end

        chan_nxt_c = chan_q;
        if (bus.sel) begin
            chan_nxt_c = (chan_q == SW'(CHANNELS - 1)) ? '0 : chan_q + SW'(1);
        end
    end

    // Encoder history, positions and the registered view of the active channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            a_qq    <= 1'b0;
            chan_q  <= '0;
            pos_q   <= POS_MID;
            level_q <= bar_of(POS_MID);
            for (int i = 0; i < int'(CHANNELS); i++) begin
                pos_arr[i] <= POS_MID;
            end
        end else begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            a_qq    <= a_q;
            chan_q  <= chan_nxt_c;
            pos_arr <= pos_nxt_c;
            pos_q   <= pos_nxt_c[chan_nxt_c];
            level_q <= bar_of(pos_nxt_c[chan_nxt_c]);
        end
    end

    // Free-running PWM period counter shared by all channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CW'(PERIOD_CYC - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_pwm
`ifdef SERVO_STAGGER_EN
        localparam logic [CW-1:0] OFF = CW'(k * (PERIOD_CYC / CHANNELS));
`else
        localparam logic [CW-1:0] OFF = '0;
`endif
        logic [CW-1:0] width_c;
        logic [CW-1:0] left;
        logic          hi;

        assign width_c = CW'(MIN_CYC) + CW'(pos_arr[k]) * CW'(STEP_CYC);

        // Width is latched into the down-counter at the start, so mid-pulse edits wait a period.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hi   <= 1'b0;
                left <= CW'(MIN_CYC) + CW'(POS_MID) * CW'(STEP_CYC) - CW'(1);
            end else if (cnt == OFF) begin
                hi   <= 1'b1;
                left <= width_c - CW'(1);
            end else if (hi) begin
                if (left == '0) begin
                    hi <= 1'b0;
                end else begin
                    left <= left - CW'(1);
                end
            end
        end

        assign servo_q[k] = hi;
    end

    assign bus.chan  = chan_q;
    assign bus.pos   = pos_q;
    assign bus.level = level_q;
    assign bus.servo = servo_q;
endmodule

// File: tb/tb_servo_array.sv
// Bench for servo_array: vector table for encoder/select behaviour, pulse scoreboard for the PWM.
module tb_servo_array;
    localparam int unsigned CH   = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned CRS  = 8;
    localparam int unsigned PER  = 1000;
    localparam int unsigned MINC = 100;
    localparam int unsigned STP  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    servo_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    servo_array #(
        .CHANNELS(CH), .WIDTH(W), .COARSE_STEP(CRS),
        .PERIOD_CYC(PER), .MIN_CYC(MINC), .STEP_CYC(STP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int nvec = 0;
    int nerr = 0;

    function automatic void chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int off_of(int k);
`ifdef SERVO_STAGGER_EN
        return k * int'(PER / CH);
`else
        return 0 * k;
`endif
    endfunction

    // Reference model: counter, positions, and expected pulse widths queued at each load.
    int mcnt = 0;
    int m_edge_cnt = 0;
    int mchan = 0;
    int mpos [CH];
    bit maq = 0, mbq = 0, maqq = 0;
    int expw [CH][$];

    initial forever begin
        int d, v;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mcnt = 0; mchan = 0; maq = 0; mbq = 0; maqq = 0;
            for (int k = 0; k < CH; k++) begin
                mpos[k] = 128;
                expw[k].delete();
            end
        end else begin
            m_edge_cnt = mcnt;
            for (int k = 0; k < CH; k++)
                if (mcnt == off_of(k)) expw[k].push_back(int'(MINC) + mpos[k] * int'(STP));
            mcnt = (mcnt + 1) % int'(PER);
            if (maq && !maqq) begin
                d = bus.coarse ? int'(CRS) : 1;
                v = mbq ? mpos[mchan] - d : mpos[mchan] + d;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                mpos[mchan] = v;
            end
            if (bus.sel) mchan = (mchan + 1) % int'(CH);
            maqq = maq;
            maq  = bus.a;
            mbq  = bus.b;
        end
    end

    // Pulse monitor: checks start counter on rise and width on fall against the model queue.
    bit prev [CH];
    int len [CH];
    int last_w [CH];
    int nfall [CH];

    initial begin
        for (int k = 0; k < CH; k++) begin
            prev[k] = 0; len[k] = 0; last_w[k] = 0; nfall[k] = 0;
        end
    end

    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
                prev[k] = 0; len[k] = 0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (bus.servo[k] && !prev[k]) begin
                    chk($sformatf("ch%0d_rise_cnt", k), m_edge_cnt, off_of(k));
                    len[k] = 1;
                end else if (bus.servo[k]) begin
                    len[k]++;
                end else if (prev[k]) begin
                    if (expw[k].size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL ch%0d_pulse: width %0d with no pulse expected", k, len[k]);
                    end else begin
                        chk($sformatf("ch%0d_width", k), len[k], expw[k].pop_front());
                    end
                    last_w[k] = len[k];
                    nfall[k]++;
                end
                prev[k] = bus.servo[k];
            end
        end
    end

    task automatic do_step(bit dir, bit crs, bit with_sel);
        @(negedge clk); bus.b = dir; bus.coarse = crs; bus.a = 1'b1;
        @(negedge clk); if (with_sel) bus.sel = 1'b1;
        @(negedge clk); bus.sel = 1'b0; bus.a = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_sel();
        @(negedge clk); bus.sel = 1'b1;
        @(negedge clk); bus.sel = 1'b0;
    endtask

    task automatic wait_fall(int k);
        int  n0 = nfall[k];
        bit  ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (nfall[k] != n0) begin ok = 1; break; end
        end
        if (!ok) begin
            nvec++; nerr++;
            $display("FAIL wait_fall_ch%0d: no pulse end within 3000 cycles", k);
        end
    endtask

    task automatic wait_servo0(bit val);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.servo[0] == val) begin ok = 1; break; end
        end
        if (!ok) begin
            nvec++; nerr++;
            $display("FAIL wait_servo0: level %0d not reached within 3000 cycles", val);
        end
    endtask

    typedef enum int {OP_CW, OP_CCW, OP_SEL, OP_SELCW} op_e;
    typedef struct {
        op_e op;
        bit  crs;
        int  n;
        int  echan;
        int  epos;
        int  elevel;
    } vec_t;

    vec_t tbl [17];
    int   rise_mask;

    initial begin
        tbl[0]  = '{OP_CW,    1'b0, 1,  0, 129, 'h1F};
        tbl[1]  = '{OP_CW,    1'b0, 1,  0, 130, 'h1F};
        tbl[2]  = '{OP_CW,    1'b0, 1,  0, 131, 'h1F};
        tbl[3]  = '{OP_CW,    1'b1, 20, 0, 255, 'hFF};
        tbl[4]  = '{OP_CCW,   1'b1, 40, 0, 0,   'h01};
        tbl[5]  = '{OP_SEL,   1'b0, 1,  1, 128, 'h1F};
        tbl[6]  = '{OP_SEL,   1'b0, 1,  2, 128, 'h1F};
        tbl[7]  = '{OP_SEL,   1'b0, 1,  3, 128, 'h1F};
        tbl[8]  = '{OP_SEL,   1'b0, 1,  0, 0,   'h01};
        tbl[9]  = '{OP_SEL,   1'b0, 2,  2, 128, 'h1F};
        tbl[10] = '{OP_SELCW, 1'b0, 1,  3, 128, 'h1F};
        tbl[11] = '{OP_SEL,   1'b0, 1,  0, 0,   'h01};
        tbl[12] = '{OP_SEL,   1'b0, 2,  2, 129, 'h1F};
        tbl[13] = '{OP_CCW,   1'b0, 1,  2, 128, 'h1F};
        tbl[14] = '{OP_CW,    1'b1, 1,  2, 136, 'h1F};
        tbl[15] = '{OP_CW,    1'b1, 4,  2, 168, 'h3F};
        tbl[16] = '{OP_CCW,   1'b1, 13, 2, 64,  'h07};

        bus.a = 1'b0; bus.b = 1'b0; bus.sel = 1'b0; bus.coarse = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_servo", int'(bus.servo), 0);
        chk("reset_pos", int'(bus.pos), 128);
        chk("reset_chan", int'(bus.chan), 0);
        chk("reset_level", int'(bus.level), 'h1F);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                case (tbl[i].op)
                    OP_CW:    do_step(1'b0, tbl[i].crs, 1'b0);
                    OP_CCW:   do_step(1'b1, tbl[i].crs, 1'b0);
                    OP_SEL:   do_sel();
                    default:  do_step(1'b0, tbl[i].crs, 1'b1);
                endcase
            end
            chk($sformatf("row%0d_chan", i), int'(bus.chan), tbl[i].echan);
            chk($sformatf("row%0d_pos", i), int'(bus.pos), tbl[i].epos);
            chk($sformatf("row%0d_level", i), int'(bus.level), tbl[i].elevel);

            if (i == 2) begin
                // Steps landed mid-pulse: this pulse keeps 356, the next one carries 131.
                wait_fall(0); chk("ch0_first_width", last_w[0], 356);
                wait_fall(1); chk("ch1_width_unchanged", last_w[1], 356);
                wait_fall(0); chk("ch0_second_width", last_w[0], 362);
            end else if (i == 3) begin
                wait_fall(0); chk("ch0_max_width", last_w[0], 610);
            end else if (i == 4) begin
                wait_fall(0); chk("ch0_min_width", last_w[0], 100);
            end
        end

        // Step latency: a sampled at edge n shows on pos only after edge n+1.
        @(negedge clk); bus.b = 1'b0; bus.coarse = 1'b0; bus.a = 1'b1;
        @(negedge clk); chk("latency_edge_n", int'(bus.pos), 64);
        @(negedge clk); chk("latency_edge_n1", int'(bus.pos), 65);
        bus.a = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset 50 cycles into a pulse.
        wait_servo0(1'b0);
        wait_servo0(1'b1);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_servo", int'(bus.servo), 0);
        chk("async_rst_pos", int'(bus.pos), 128);
        chk("async_rst_chan", int'(bus.chan), 0);
        chk("async_rst_level", int'(bus.level), 'h1F);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        rise_mask = 0;
        for (int k = 0; k < CH; k++) if (off_of(k) == 0) rise_mask |= (1 << k);
        @(negedge clk);
        chk("post_rst_rise", int'(bus.servo), rise_mask);
        do_sel(); do_sel();
        chk("post_rst_ch2_chan", int'(bus.chan), 2);
        chk("post_rst_ch2_pos", int'(bus.pos), 128);
        wait_fall(0); chk("post_rst_width", last_w[0], 356);

        for (int k = 0; k < CH; k++) begin
            chk($sformatf("ch%0d_pulses_seen", k), int'(nfall[k] >= 4), 1);
            chk($sformatf("ch%0d_pending", k), int'(expw[k].size() <= 1), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/servo_array.md
# servo_array

Multi-channel successor to the single-servo encoder control path. Takes debounced rotary-encoder levels and a select pulse, and keeps one position register per servo channel. The encoder adjusts the active channel with saturating fine or coarse steps. It generates glitch-free PWM for every channel, with an optional phase stagger. It sits between the debouncers and the servo pins, replacing the decoder, control-unit and driver chain for multi-servo builds.

## Interface
- CHANNELS, 4, number of servo channels (≥2)
- WIDTH, 8, position register width (≥3)
- COARSE_STEP, 8, position increment when `coarse` is high
- PERIOD_CYC, 1000000, PWM period in clk cycles
- MIN_CYC, 50000, pulse width at position 0
- STEP_CYC, 196, extra pulse cycles per position LSB; MIN_CYC + (2^WIDTH−1)·STEP_CYC < PERIOD_CYC is required

Ports:
- clk  in  1  system clock; the single clock for the block
- rst_n  in  1  asynchronous, active-low reset
- a  in  1  debounced encoder CLK level
- b  in  1  debounced encoder DT level
- sel  in  1  one-cycle pulse that advances the active channel
- coarse  in  1  level; selects COARSE_STEP instead of 1
- chan  out  clog2(CHANNELS)  active channel index
- pos  out  WIDTH  position of the active channel
- level  out  8  thermometer bar of `pos`
- servo  out  CHANNELS  PWM outputs, one bit per channel

## Operation
- Reset values:
  - every position register = 2^(WIDTH−1)
  - chan = 0
  - servo = all 0
  - period counter = 0
  - shadow widths = MIN_CYC + 2^(WIDTH−1)·STEP_CYC
  - a/b history registers = 0
- Quadrature decode:
  - `a` and `b` are registered once into a_q and b_q; a_q is registered again into a_qq.
  - A step event occurs when a_q=1 and a_qq=0.
  - b_q=0 means CW (increment); b_q=1 means CCW (decrement).
- Step size is 1, or COARSE_STEP if `coarse`=1 at the event.
- Arithmetic is saturating:
  - increments clamp at 2^WIDTH−1
  - decrements clamp at 0
  - no wrap-around in either direction
- Channel select:
  - `sel` advances chan by 1.
  - chan wraps from CHANNELS−1 to 0.
- Simultaneous `sel` and step event in the same cycle: the step applies to the old channel, then chan advances.
- level[i] = 1 when pos[WIDTH−1:WIDTH−3] ≥ i, for i = 0..7. So level[0] is always 1, and pos 2^(WIDTH−1) gives 8'b0001_1111.
- PWM engine:
  - One free-running counter runs 0..PERIOD_CYC−1 and wraps.
  - Channel k has a start offset off_k (see Configuration).
  - When the counter equals off_k, channel k's shadow width is loaded with MIN_CYC + pos_k·STEP_CYC.
  - servo[k] is high for exactly that many cycles from that point; the pulse may span the counter wrap.
- Position changes during a pulse never alter that pulse; they take effect at the channel's next start.

## Timing
- `a` sampled high at edge n: position updates at edge n+1.
- `pos` and `level` reflect the change after edge n+1.
- `sel` high at edge n: chan changes at edge n+1.
- Shadow load and rise of servo[k] occur at the same edge.
- servo[k] falls exactly `width` cycles after it rises.
- Asserting rst_n low forces all outputs to reset values immediately, with no clock needed, including mid-pulse.
- After rst_n is released, the first pulse on each channel starts when the counter first reaches off_k.

## Configuration
- SERVO_STAGGER_EN defined: off_k = k·(PERIOD_CYC/CHANNELS), with integer division. This spreads pulse starts across the period to reduce supply current peaks.
- SERVO_STAGGER_EN undefined: off_k = 0 for all k, so all channels rise on the same edge.

## Test plan
Bench parameters: CHANNELS=4, WIDTH=8, COARSE_STEP=8, PERIOD_CYC=1000, MIN_CYC=100, STEP_CYC=2; stagger off unless stated.

- Reset release -> pos=128, chan=0, level=8'h1F; every servo bit is high for 356 cycles starting at counter 0, every 1000 cycles.
- Three CW events (b=0) on chan 0, with the first issued mid-pulse -> pos=131; the current pulse stays 356 cycles; the next pulse is 362 cycles; channels 1–3 are unchanged.
- coarse=1, 20 CW events -> pos clamps at 255, width 610, level=8'hFF. Then 40 CCW events -> pos=0, width 100, level=8'h01.
- Four `sel` pulses -> chan sequence 1,2,3,0. `sel` and a CW event in the same cycle on chan 2 -> channel 2 increments and chan becomes 3.
- SERVO_STAGGER_EN defined -> servo[0..3] rise at counter 0, 250, 500 and 750. A width of 356 on channel 3 spans the wrap and falls at counter 106.
- rst_n low 50 cycles into a pulse -> all servo bits low at once and positions return to 128. After release, pulses restart at counter 0.
